// File: rtl/tmr0_timer.sv
// tmr0_timer: PIC16C5x Timer0, 8-bit counter with programmable prescaler and T0CKI sync
module tmr0_timer #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  optionWrite,
   input  logic [5:0]            optionIn,
   input  logic                  tmrWrite,
   input  logic [DATA_WIDTH-1:0] writeDataIn,
   input  logic                  t0ckiIn,
   output logic [DATA_WIDTH-1:0] tmr0Out,
   output logic [5:0]            optionOut,
   output logic                  overflowOut
);
   logic s1, s2, s3;
   logic [PRESCALE_WIDTH-1:0] prescaler, prescMask;
   logic [1:0] inhibit;
   logic srcEvent, cntEvent, tick;
   // event source select, write-inhibit gating and prescaler tap (old OPTION applies this cycle)
   always_comb begin
      srcEvent  = optionOut[5] ? (optionOut[4] ? (~s2 & s3) : (s2 & ~s3)) : 1'b1;
      cntEvent  = srcEvent & (inhibit == 2'd0);
      prescMask = ~({PRESCALE_WIDTH{1'b1}} << ({1'b0, optionOut[2:0]} + 4'd1));
      tick      = cntEvent & (optionOut[3] | ((prescaler & prescMask) == prescMask));
   end
   // two-flop synchronizer plus edge history; runs regardless of T0CS
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= t0ckiIn;
         s2 <= s1;
         s3 <= s2;
      end
   end
   // OPTION register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) optionOut <= 6'b111111;
      else optionOut <= optionWrite ? optionIn : optionOut;
   end
   // prescaler: cleared by either write or while bypassed, otherwise counts accepted events
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prescaler <= '0;
      else prescaler <= (optionWrite | tmrWrite | optionOut[3]) ? '0 :
                        cntEvent ? prescaler + PRESCALE_WIDTH'(1) : prescaler;
   end
   // inhibit window: events after a TMR0 write are dropped for two cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) inhibit <= 2'd0;
      else inhibit <= tmrWrite ? 2'd2 : (inhibit != 2'd0) ? inhibit - 2'd1 : 2'd0;
   end
   // counter and overflow pulse; a write overrides any tick in the same cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr0Out     <= '0;
         overflowOut <= 1'b0;
      end else begin
         tmr0Out     <= tmrWrite ? writeDataIn : tick ? tmr0Out + DATA_WIDTH'(1) : tmr0Out;
         overflowOut <= tick & ~tmrWrite & (&tmr0Out);
      end
   end
endmodule

// File: tb/tb_tmr0_timer.sv
// tb_tmr0_timer: vector table, corner sequences and random run against a reference model
module tb_tmr0_timer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic optionWrite = 1'b0;
   logic [5:0] optionIn = '0;
   logic tmrWrite = 1'b0;
   logic [7:0] writeDataIn = '0;
   logic t0ckiIn = 1'b0;
   logic [7:0] tmr0Out;
   logic [5:0] optionOut;
   logic overflowOut;

   int nPass = 0;
   int nTotal = 0;

   tmr0_timer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .optionWrite(optionWrite), .optionIn(optionIn),
      .tmrWrite(tmrWrite), .writeDataIn(writeDataIn), .t0ckiIn(t0ckiIn),
      .tmr0Out(tmr0Out), .optionOut(optionOut), .overflowOut(overflowOut)
   );

   always #5 clk = ~clk;

   // reference model state
   int mTmr, mPre, mInhib;
   logic [5:0] mOpt;
   bit mOvf;
   bit pinHist[$];

   task automatic mReset();
      mTmr = 0; mPre = 0; mInhib = 0; mOpt = 6'h3F; mOvf = 0;
      pinHist = {1'b0, 1'b0, 1'b0};
   endtask

   task automatic mStep();
      bit ext, ev, tk;
      int ratio;
      ext = mOpt[4] ? (!pinHist[1] && pinHist[0]) : (pinHist[1] && !pinHist[0]);
      ev = (mOpt[5] ? ext : 1'b1) && (mInhib == 0);
      ratio = 1 << (int'(mOpt[2:0]) + 1);
      tk = ev && (mOpt[3] || (mPre % ratio) == ratio - 1);
      mOvf = tk && !tmrWrite && (mTmr == 255);
      if (ev) mPre++;
      if (mOpt[3] || optionWrite || tmrWrite) mPre = 0;
      mInhib = tmrWrite ? 2 : (mInhib > 0 ? mInhib - 1 : 0);
      mTmr = tmrWrite ? int'(writeDataIn) : tk ? (mTmr + 1) % 256 : mTmr;
      if (optionWrite) mOpt = optionIn;
      pinHist.push_back(t0ckiIn);
      void'(pinHist.pop_front());
   endtask

   task automatic step();
      mStep();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      nTotal++;
      if (act == exp) nPass++;
      else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
   endtask

   task automatic drive(input logic ow, input logic [5:0] opt, input logic tw, input logic [7:0] d);
      optionWrite = ow; optionIn = opt; tmrWrite = tw; writeDataIn = d;
   endtask

   task automatic idle();
      drive(1'b0, 6'h00, 1'b0, 8'h00);
   endtask

   typedef struct {
      logic ow; logic [5:0] opt; logic tw; logic [7:0] d;
      logic [7:0] eTmr; logic [5:0] eOpt; logic eOvf;
   } vec_t;
   vec_t vt[$];

   task automatic addV(input logic ow, input logic [5:0] opt, input logic tw, input logic [7:0] d,
                       input logic [7:0] eTmr, input logic [5:0] eOpt, input logic eOvf);
      vec_t v;
      v.ow = ow; v.opt = opt; v.tw = tw; v.d = d; v.eTmr = eTmr; v.eOpt = eOpt; v.eOvf = eOvf;
      vt.push_back(v);
   endtask

   task automatic extRun(input logic [5:0] opt, input string nm);
      int exp;
      t0ckiIn = 1'b0;
      drive(1'b1, opt, 1'b1, 8'h10);
      step();
      idle();
      step();
      step();
      exp = 8'h10;
      chk({nm, "_start"}, tmr0Out, exp);
      for (int p = 0; p < 4; p++) begin
         for (int h = 0; h < 6; h++) begin
            t0ckiIn = (h < 3);
            step();
            if ((!opt[4] && h == 2) || (opt[4] && h == 5)) exp++;
            chk(nm, tmr0Out, exp);
         end
      end
   endtask

   initial begin
      int n, ovfCount, pinLeft;
      mReset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tmr", tmr0Out, 0);
      chk("reset_opt", optionOut, 6'h3F);
      chk("reset_ovf", overflowOut, 0);
      rst = 1'b1;

      // vector table: free run, write inhibit, overflow, write-over-tick, prescaler 1:8, dual write
      addV(1, 6'h08, 0, 8'h00, 8'h00, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h01, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h02, 6'h08, 0);
      addV(0, 6'h00, 1, 8'hFE, 8'hFE, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'hFE, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'hFE, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'hFF, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h00, 6'h08, 1);
      addV(0, 6'h00, 0, 8'h00, 8'h01, 6'h08, 0);
      addV(0, 6'h00, 1, 8'hFF, 8'hFF, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'hFF, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'hFF, 6'h08, 0);
      addV(0, 6'h00, 1, 8'h00, 8'h00, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h00, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h00, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h01, 6'h08, 0);
      addV(1, 6'h02, 0, 8'h00, 8'h02, 6'h02, 0);
      for (int i = 0; i < 7; i++) addV(0, 6'h00, 0, 8'h00, 8'h02, 6'h02, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h03, 6'h02, 0);
      for (int i = 0; i < 7; i++) addV(0, 6'h00, 0, 8'h00, 8'h03, 6'h02, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h04, 6'h02, 0);
      addV(1, 6'h08, 1, 8'h55, 8'h55, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h55, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h55, 6'h08, 0);
      addV(0, 6'h00, 0, 8'h00, 8'h56, 6'h08, 0);
      foreach (vt[i]) begin
         drive(vt[i].ow, vt[i].opt, vt[i].tw, vt[i].d);
         step();
         chk($sformatf("vec%0d_tmr", i), tmr0Out, vt[i].eTmr);
         chk($sformatf("vec%0d_opt", i), optionOut, vt[i].eOpt);
         chk($sformatf("vec%0d_ovf", i), overflowOut, vt[i].eOvf);
      end
      idle();

      // free run for a full wrap: exactly one overflow pulse
      drive(1'b1, 6'h08, 1'b1, 8'h00);
      step();
      idle();
      step();
      step();
      chk("freerun_hold", tmr0Out, 0);
      ovfCount = 0;
      for (int i = 1; i <= 257; i++) begin
         step();
         chk("freerun_cnt", tmr0Out, i % 256);
         if (overflowOut) ovfCount++;
         if (i == 256) chk("freerun_ovf", overflowOut, 1);
      end
      chk("freerun_ovf_count", ovfCount, 1);

      // 1:256 prescaler: first step after inhibit plus 256 events, then every 256
      drive(1'b1, 6'h07, 1'b1, 8'h20);
      step();
      idle();
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         step();
         n = i;
         if (tmr0Out != 8'h20) break;
      end
      chk("ps256_first", n, 258);
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         step();
         n = i;
         if (tmr0Out != 8'h21) break;
      end
      chk("ps256_period", n, 256);
      chk("ps256_value", tmr0Out, 8'h22);

      // external clock, rising then falling edges, period 6 cycles
      extRun(6'h28, "ext_rise");
      extRun(6'h38, "ext_fall");
      t0ckiIn = 1'b0;
      idle();
      repeat (4) step();

      // async reset inside the inhibit window
      drive(1'b0, 6'h00, 1'b1, 8'h40);
      step();
      idle();
      #2 rst = 1'b0;
      #1;
      mReset();
      chk("rst_inhib_tmr", tmr0Out, 0);
      chk("rst_inhib_opt", optionOut, 6'h3F);
      chk("rst_inhib_ovf", overflowOut, 0);
      #2 rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("rst_static_pin", tmr0Out, 0);
      end

      // randomized run against the reference model, with one mid-run async reset
      pinLeft = 2;
      for (int i = 0; i < 1500; i++) begin
         optionWrite = ($urandom_range(0, 39) == 0);
         optionIn = 6'($urandom_range(0, 63));
         if (optionWrite && $urandom_range(0, 1) == 1) optionIn[2:0] = 3'($urandom_range(0, 2));
         tmrWrite = ($urandom_range(0, 29) == 0);
         writeDataIn = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255));
         if (pinLeft == 0) begin
            t0ckiIn = ~t0ckiIn;
            pinLeft = $urandom_range(2, 5);
         end
         pinLeft--;
         step();
         chk("rand_tmr", tmr0Out, mTmr);
         chk("rand_opt", optionOut, mOpt);
         chk("rand_ovf", overflowOut, mOvf);
         if (i == 700) begin
            #2 rst = 1'b0;
            #1;
            mReset();
            chk("rand_rst_tmr", tmr0Out, 0);
            chk("rand_rst_opt", optionOut, 6'h3F);
            #2 rst = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end
endmodule
